cpu_bus_decoder: RTL and testbench
==================================

Name: cpu_bus_decoder

Overview:
- Sits directly downstream of the RV32 CPU core's single request/ready memory bus.
- Decodes each CPU request into one of three targets: ROM, RAM or IO. Anything else is unmapped.
- Forwards the request to the selected target, waits for that target's ready, then returns one registered ready pulse with read data to the CPU.
- Flags illegal and unmapped accesses on a fault strobe.

Parameters:
- ROM_BASE, 32'h0000_0000, ROM region base; region = base + 2^ROM_BITS bytes.
- ROM_BITS, 16, log2 of ROM region size in bytes.
- RAM_BASE, 32'h0001_0000, RAM region base.
- RAM_BITS, 16, log2 of RAM region size in bytes.
- IO_BASE, 32'h5000_0000, IO region base.
- IO_BITS, 12, log2 of IO region size in bytes.
- TIMEOUT_CYCLES, 255, wait limit in cycles; used only with BUS_TIMEOUT_EN.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_request  in  1  CPU request, held high until o_ready
- i_rw  in  1  0 = read, 1 = write
- i_address  in  32  CPU byte address
- i_wdata  in  32  CPU write data
- o_rdata  out  32  read data, valid while o_ready is high
- o_ready  out  1  one-cycle completion pulse
- o_fault  out  1  one-cycle pulse, concurrent with o_ready on a faulting access
- o_t_rw  out  1  target rw, shared by all targets
- o_t_address  out  32  target address: full address minus the selected region base
- o_t_wdata  out  32  target write data, shared by all targets
- o_rom_request, o_ram_request, o_io_request  out  1 each  per-target request
- i_rom_rdata, i_ram_rdata, i_io_rdata  in  32 each  per-target read data
- i_rom_ready, i_ram_ready, i_io_ready  in  1 each  per-target ready

Behaviour:
- Clock and reset: one clock (i_clock). Reset i_reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States: IDLE, ACTIVE, ACK.

IDLE:
- If i_request = 1, register i_rw, i_wdata and o_t_address (offset) at the current edge.
- Decode on the full address. Region hit = (i_address & ~(2^BITS-1)) == BASE.
- If regions overlap, priority is ROM > RAM > IO.
- Legal hit: assert the matching o_*_request and go to ACTIVE.
- ROM write, or unmapped address: no target request. Go to ACK with o_ready = 1, o_fault = 1, o_rdata = 0. A ROM write is dropped.

ACTIVE:
- Hold the target request and the shared outputs stable.
- Sample only the selected target's ready; all other ready inputs are ignored.
- On ready = 1 at an edge:
  - deassert the target request;
  - o_rdata <= that target's rdata on a read, 0 on a write;
  - o_ready <= 1;
  - go to ACK.

ACK:
- o_ready is high for exactly this one cycle.
- Next edge: o_ready <= 0, o_fault <= 0, go to IDLE.
- The CPU drops i_request on the same edge it samples o_ready, so returning to IDLE cannot re-trigger the same access.

Latency:
- Request sampled at edge N; target request visible after edge N.
- Target ready at edge M gives o_ready high during cycle M+1.
- Fault path: o_ready high during cycle N+1.

Other rules:
- i_request dropping during ACTIVE (protocol violation) is ignored; the transaction completes normally.
- Target ready pulses seen in IDLE or ACK are ignored.
- Reset asserted mid-transaction: all requests drop immediately (asynchronously), state returns to IDLE, and no o_ready is issued.
- At most one target request is high at any time.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT_CYCLES with no target ready, the target request drops and the block goes to ACK with o_ready = 1, o_fault = 1, o_rdata = 0.
  - Ready arriving on the same edge as expiry wins: normal completion, no fault.
- Undefined: no counter is built; ACTIVE waits indefinitely.

Test Plan:
- Read 0x0000_0010, ROM ready 2 cycles later with data 0x0000_0513 -> o_rom_request high with o_t_address = 0x10; o_ready one cycle with o_rdata = 0x0000_0513; o_fault = 0.
- Write 0x0001_1FFC with data 0xCAFEBABE, RAM ready immediately -> o_ram_request with o_t_address = 0x1FFC and o_t_wdata = 0xCAFEBABE; o_ready one cycle; o_rdata = 0.
- Write 0x0000_0004 (ROM) -> no target request; o_ready and o_fault both high in cycle N+1.
- Read 0x8000_0000 (unmapped) -> no target request; o_ready = 1, o_fault = 1, o_rdata = 0.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, read 0x5000_0004 with IO never ready -> o_io_request drops after 8 ACTIVE cycles; o_ready = 1, o_fault = 1. Repeat with i_io_ready arriving on the expiry edge -> no fault, IO data returned.
- Assert i_reset during ACTIVE on a RAM read -> o_ram_request = 0 immediately; no o_ready; the next request after reset decodes normally.

Source files
------------

// File: rtl/cpu_bus_decoder.sv
// CPU bus decoder: routes each CPU request to ROM, RAM or IO and returns one registered ready pulse.
// Optional wait-limit on target ready is built when BUS_TIMEOUT_EN is defined.
module cpu_bus_decoder #(
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter int          ROM_BITS       = 16,
  parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
  parameter int          RAM_BITS       = 16,
  parameter logic [31:0] IO_BASE        = 32'h5000_0000,
  parameter int          IO_BITS        = 12,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_fault,
  output logic        o_t_rw,
  output logic [31:0] o_t_address,
  output logic [31:0] o_t_wdata,
  output logic        o_rom_request,
  output logic        o_ram_request,
  output logic        o_io_request,
  input  logic [31:0] i_rom_rdata,
  input  logic [31:0] i_ram_rdata,
  input  logic [31:0] i_io_rdata,
  input  logic        i_rom_ready,
  input  logic        i_ram_ready,
  input  logic        i_io_ready,
  output logic [1:0]  o_state
);

  // Handshake: the CPU holds i_request until it samples o_ready; each target holds
  // its request until its ready is seen at an edge, then the request drops.
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, ACK = 2'd2} state_t;
  typedef enum logic [1:0] {TGT_NONE = 2'd0, TGT_ROM = 2'd1, TGT_RAM = 2'd2, TGT_IO = 2'd3} tgt_t;

  localparam logic [31:0] ROM_MASK = ~((32'd1 << ROM_BITS) - 32'd1);
  localparam logic [31:0] RAM_MASK = ~((32'd1 << RAM_BITS) - 32'd1);
  localparam logic [31:0] IO_MASK  = ~((32'd1 << IO_BITS) - 32'd1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_n;
  tgt_t        tgt, tgt_n;
  logic [31:0] rdata_n, t_address_n, t_wdata_n;
  logic        ready_n, fault_n, t_rw_n;
  logic        rom_req_n, ram_req_n, io_req_n;
  logic        rom_hit, ram_hit, io_hit;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  assign rom_hit = (i_address & ROM_MASK) == ROM_BASE;
  assign ram_hit = (i_address & RAM_MASK) == RAM_BASE;
  assign io_hit  = (i_address & IO_MASK) == IO_BASE;
  assign o_state = state;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'd0;
    case (tgt)
      TGT_ROM: begin sel_ready = i_rom_ready; sel_rdata = i_rom_rdata; end
      TGT_RAM: begin sel_ready = i_ram_ready; sel_rdata = i_ram_rdata; end
      TGT_IO:  begin sel_ready = i_io_ready;  sel_rdata = i_io_rdata;  end
      default: ;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt <= '0;
    else         cnt <= cnt_n;
  end
`endif

  always_comb begin
    state_n     = state;
    tgt_n       = tgt;
    rdata_n     = o_rdata;
    ready_n     = o_ready;
    fault_n     = o_fault;
    t_rw_n      = o_t_rw;
    t_address_n = o_t_address;
    t_wdata_n   = o_t_wdata;
    rom_req_n   = o_rom_request;
    ram_req_n   = o_ram_request;
    io_req_n    = o_io_request;
`ifdef BUS_TIMEOUT_EN
    cnt_n       = cnt;
`endif
    case (state)
      IDLE: begin
        if (i_request) begin
          t_rw_n    = i_rw;
          t_wdata_n = i_wdata;
          state_n   = ACTIVE;
`ifdef BUS_TIMEOUT_EN
          cnt_n     = '0;
`endif
          if (rom_hit) begin
            t_address_n = i_address - ROM_BASE;
            tgt_n       = TGT_ROM;
            rom_req_n   = ~i_rw;
          end else if (ram_hit) begin
            t_address_n = i_address - RAM_BASE;
            tgt_n       = TGT_RAM;
            ram_req_n   = 1'b1;
          end else if (io_hit) begin
            t_address_n = i_address - IO_BASE;
            tgt_n       = TGT_IO;
            io_req_n    = 1'b1;
          end else begin
            t_address_n = i_address;
            tgt_n       = TGT_NONE;
          end
          // ROM writes and unmapped addresses complete at once with a fault.
          if (!(rom_hit && !i_rw) && !ram_hit && !(io_hit && !rom_hit)) begin
            tgt_n   = TGT_NONE;
            ready_n = 1'b1;
            fault_n = 1'b1;
            rdata_n = 32'd0;
            state_n = ACK;
          end
        end
      end
      ACTIVE: begin
        if (sel_ready) begin
          rom_req_n = 1'b0;
          ram_req_n = 1'b0;
          io_req_n  = 1'b0;
          rdata_n   = o_t_rw ? 32'd0 : sel_rdata;
          ready_n   = 1'b1;
          state_n   = ACK;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          rom_req_n = 1'b0;
          ram_req_n = 1'b0;
          io_req_n  = 1'b0;
          rdata_n   = 32'd0;
          ready_n   = 1'b1;
          fault_n   = 1'b1;
          state_n   = ACK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      ACK: begin
        ready_n = 1'b0;
        fault_n = 1'b0;
        tgt_n   = TGT_NONE;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      tgt           <= TGT_NONE;
      o_rdata       <= 32'd0;
      o_ready       <= 1'b0;
      o_fault       <= 1'b0;
      o_t_rw        <= 1'b0;
      o_t_address   <= 32'd0;
      o_t_wdata     <= 32'd0;
      o_rom_request <= 1'b0;
      o_ram_request <= 1'b0;
      o_io_request  <= 1'b0;
    end else begin
      state         <= state_n;
      tgt           <= tgt_n;
      o_rdata       <= rdata_n;
      o_ready       <= ready_n;
      o_fault       <= fault_n;
      o_t_rw        <= t_rw_n;
      o_t_address   <= t_address_n;
      o_t_wdata     <= t_wdata_n;
      o_rom_request <= rom_req_n;
      o_ram_request <= ram_req_n;
      o_io_request  <= io_req_n;
    end
  end

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Bench for cpu_bus_decoder: vector table, random RAM traffic and hand-written
// reset / protocol / timeout sequences, with an ordered queue of expected responses.
module tb_cpu_bus_decoder;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0, i_rw = 1'b0;
  logic [31:0] i_address = '0, i_wdata = '0;
  logic [31:0] o_rdata, o_t_address, o_t_wdata;
  logic        o_ready, o_fault, o_t_rw;
  logic        o_rom_request, o_ram_request, o_io_request;
  logic [31:0] i_rom_rdata = '0, i_ram_rdata = '0, i_io_rdata = '0;
  logic        i_rom_ready = 1'b0, i_ram_ready = 1'b0, i_io_ready = 1'b0;
  logic [1:0]  o_state;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {fault, rdata}

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] tdata;
    int          tgt;    // 0 none/fault, 1 rom, 2 ram, 3 io
    logic [31:0] toff;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  cpu_bus_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
    .o_fault(o_fault), .o_t_rw(o_t_rw), .o_t_address(o_t_address), .o_t_wdata(o_t_wdata),
    .o_rom_request(o_rom_request), .o_ram_request(o_ram_request), .o_io_request(o_io_request),
    .i_rom_rdata(i_rom_rdata), .i_ram_rdata(i_ram_rdata), .i_io_rdata(i_io_rdata),
    .i_rom_ready(i_rom_ready), .i_ram_ready(i_ram_ready), .i_io_ready(i_io_ready),
    .o_state(o_state)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every o_ready pulse consumes one expected response.
  always @(posedge i_clock) begin
    #1;
    if (o_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("sb_rdata", o_rdata, e[31:0]);
        check("sb_fault", {31'd0, o_fault}, {31'd0, e[32]});
      end
    end
  end

  function automatic logic [2:0] req_mask(input int tgt);
    case (tgt)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Random ready/data on every target except the selected one, which must be ignored.
  task automatic noise(input int sel);
    if (sel != 1) begin i_rom_ready = 1'($urandom_range(0, 1)); i_rom_rdata = $urandom; end
    if (sel != 2) begin i_ram_ready = 1'($urandom_range(0, 1)); i_ram_rdata = $urandom; end
    if (sel != 3) begin i_io_ready  = 1'($urandom_range(0, 1)); i_io_rdata  = $urandom; end
  endtask

  task automatic set_ready(input int sel, input logic r, input logic [31:0] d);
    case (sel)
      1: begin i_rom_ready = r; i_rom_rdata = d; end
      2: begin i_ram_ready = r; i_ram_rdata = d; end
      3: begin i_io_ready  = r; i_io_rdata  = d; end
      default: ;
    endcase
  endtask

  task automatic step(input int sel);
    noise(sel);
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [2:0] reqs();
    return {o_rom_request, o_ram_request, o_io_request};
  endfunction

  task automatic run_vec(input vec_t v);
    i_request = 1'b1; i_rw = v.rw; i_address = v.addr; i_wdata = v.wdata;
    set_ready(v.tgt, 1'b0, 32'd0);
    exp_q.push_back({v.fault, v.rdata});
    step(v.tgt);
    check("req_after_N", {29'd0, reqs()}, {29'd0, req_mask(v.tgt)});
    if (v.tgt == 0) begin
      check("fault_ready_N1", {31'd0, o_ready}, 32'd1);
      i_request = 1'b0;
    end else begin
      check("t_address", o_t_address, v.toff);
      check("t_rw", {31'd0, o_t_rw}, {31'd0, v.rw});
      if (v.rw) check("t_wdata", o_t_wdata, v.wdata);
      for (int d = 0; d < v.delay; d++) begin
        step(v.tgt);
        check("req_held", {29'd0, reqs()}, {29'd0, req_mask(v.tgt)});
        check("no_early_ready", {31'd0, o_ready}, 32'd0);
      end
      set_ready(v.tgt, 1'b1, v.tdata);
      step(v.tgt);
      set_ready(v.tgt, 1'b0, 32'd0);
      check("req_dropped", {29'd0, reqs()}, 32'd0);
      check("ready_M1", {31'd0, o_ready}, 32'd1);
      i_request = 1'b0;
    end
    step(0);
    check("ready_one_cycle", {31'd0, o_ready}, 32'd0);
    check("fault_cleared", {31'd0, o_fault}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         2, 32'h0000_0513, 1, 32'h10,   32'h0000_0513, 1'b0};
    vecs[1] = '{1'b1, 32'h0001_1FFC, 32'hCAFE_BABE, 0, 32'h1111_2222, 2, 32'h1FFC, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h1234_0000, 0, 32'h0,         0, 32'h0,    32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h0,         0, 32'h0,         0, 32'h0,    32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h5000_0004, 32'h0,         1, 32'h1234_5678, 3, 32'h4,    32'h1234_5678, 1'b0};
    vecs[5] = '{1'b0, 32'h0001_FFFC, 32'h0,         3, 32'hA5A5_5A5A, 2, 32'hFFFC, 32'hA5A5_5A5A, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 32'h0,         0, 32'h0BAD_F00D, 1, 32'hFFFC, 32'h0BAD_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h5000_1000, 32'h0,         0, 32'h0,         0, 32'h0,    32'h0,         1'b1};
    vecs[8] = '{1'b1, 32'h5000_0FFC, 32'h0000_0055, 0, 32'h7777_7777, 3, 32'hFFC,  32'h0,         1'b0};
    vecs[9] = '{1'b0, 32'h0002_0000, 32'h0,         0, 32'h0,         0, 32'h0,    32'h0,         1'b1};

    // Reset state.
    repeat (3) step(0);
    check("rst_reqs", {29'd0, reqs()}, 32'd0);
    check("rst_ready_fault", {30'd0, o_ready, o_fault}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_t_address", o_t_address, 32'd0);
    check("rst_state", {30'd0, o_state}, 32'd0);
    i_reset = 1'b0;
    step(0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Random RAM traffic.
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      v.rw    = 1'($urandom_range(0, 1));
      v.toff  = 32'($urandom_range(0, 16'hFFFF)) & 32'hFFFC;
      v.addr  = 32'h0001_0000 + v.toff;
      v.wdata = $urandom;
      v.delay = $urandom_range(0, 3);
      v.tdata = $urandom;
      v.tgt   = 2;
      v.rdata = v.rw ? 32'd0 : v.tdata;
      v.fault = 1'b0;
      run_vec(v);
    end

    // Reset in the middle of a RAM read: requests drop immediately, no ready.
    i_request = 1'b1; i_rw = 1'b0; i_address = 32'h0001_0040;
    set_ready(2, 1'b0, 32'd0);
    step(2);
    step(2);
    check("mid_rst_req_before", {29'd0, reqs()}, 32'b010);
    i_reset = 1'b1;
    #1;
    check("mid_rst_req_async", {29'd0, reqs()}, 32'd0);
    check("mid_rst_state", {30'd0, o_state}, 32'd0);
    i_request = 1'b0;
    step(0);
    i_reset = 1'b0;
    step(0);
    step(0);
    check("mid_rst_no_ready", {31'd0, o_ready}, 32'd0);
    run_vec('{1'b0, 32'h0001_0040, 32'h0, 1, 32'h4242_4242, 2, 32'h40, 32'h4242_4242, 1'b0});

    // i_request dropped while ACTIVE: the transaction still completes.
    i_request = 1'b1; i_rw = 1'b0; i_address = 32'h5000_0010;
    set_ready(3, 1'b0, 32'd0);
    exp_q.push_back({1'b0, 32'hDEAD_0001});
    step(3);
    i_request = 1'b0;
    step(3);
    check("drop_req_held", {29'd0, reqs()}, 32'b001);
    set_ready(3, 1'b1, 32'hDEAD_0001);
    step(3);
    set_ready(3, 1'b0, 32'd0);
    check("drop_ready", {31'd0, o_ready}, 32'd1);
    step(0);
    check("drop_idle", {30'd0, o_state}, 32'd0);

`ifdef BUS_TIMEOUT_EN
    // IO never ready: request held for 8 ACTIVE cycles then a faulting completion.
    i_request = 1'b1; i_rw = 1'b0; i_address = 32'h5000_0004;
    set_ready(3, 1'b0, 32'd0);
    exp_q.push_back({1'b1, 32'h0});
    step(3);
    for (int c = 1; c < 8; c++) begin
      step(3);
      check("to_req_held", {29'd0, reqs()}, 32'b001);
    end
    step(3);
    check("to_req_dropped", {29'd0, reqs()}, 32'd0);
    check("to_ready", {31'd0, o_ready}, 32'd1);
    i_request = 1'b0;
    step(0);

    // Ready on the expiry edge wins: normal completion with IO data.
    i_request = 1'b1;
    exp_q.push_back({1'b0, 32'h600D_DA7A});
    step(3);
    for (int c = 1; c < 8; c++) step(3);
    set_ready(3, 1'b1, 32'h600D_DA7A);
    step(3);
    set_ready(3, 1'b0, 32'd0);
    check("tie_ready", {31'd0, o_ready}, 32'd1);
    i_request = 1'b0;
    step(0);
`endif

    repeat (2) step(0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
